crc_checker: RTL and testbench
==============================

CRC_CHECKER -- requirements
Module: crc_checker

Interface
REQ-001 SHALL have parameter Seed, default 8'hD8, the LFSR preload value, identical to the generator's Seed.
REQ-002 SHALL have parameter TAPS, default 8'h44, the feedback XOR mask over LFSR bits [6:0].
REQ-003 SHALL have parameter DATA_WD, default 8, the number of payload bits per frame.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port DATA, input, 1 bit: the serial line, carrying payload LSB first and then CRC LSB first.
REQ-007 SHALL have port ACTIVE, input, 1 bit: when high, DATA carries a payload bit.
REQ-008 SHALL have port Valid, input, 1 bit: when high, DATA carries a CRC bit.
REQ-009 SHALL have port DATA_OUT, output, DATA_WD bits: the captured payload.
REQ-010 SHALL have port CRC_OK, output, 1 bit: one-cycle pulse for a good frame.
REQ-011 SHALL have port CRC_ERR, output, 1 bit: one-cycle pulse for a CRC mismatch.
REQ-012 SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse for a protocol violation.
REQ-013 SHALL have port Busy, output, 1 bit: high while a frame is in progress (states DATA_S and CRC_S).

Function
REQ-014 SHALL implement FSM states IDLE, DATA_S and CRC_S.
REQ-015 LFSR update per payload bit SHALL be: fb = R[0]^DATA; R'[7] = fb; R'[i] = R[i+1]^(TAPS[i]&fb) for i = 0..6.
REQ-016 IDLE SHALL hold R = Seed and bit count 0; when ACTIVE=1 it SHALL apply the first LFSR update, capture the bit, and go to DATA_S.
REQ-017 DATA_S, for each ACTIVE=1 cycle: SHALL apply the LFSR update, shift DATA into DATA_OUT at MSB (right shift, so bit 0 ends as the first received bit), and increment the count.
REQ-018 DATA_S to CRC_S: on the first cycle with Valid=1 and ACTIVE=0, SHALL compare DATA with R[0], set the mismatch flag on inequality, and shift R right by 1; the payload count must equal DATA_WD.
REQ-019 CRC_S SHALL perform the same compare-and-shift on each Valid=1 cycle until 8 CRC bits have been consumed.
REQ-020 Result: at the rising edge that samples the 8th CRC bit, SHALL register CRC_OK=1 if the mismatch flag is 0, else CRC_ERR=1, for exactly 1 cycle, and return to IDLE with R = Seed.
REQ-021 DATA_OUT SHALL update only during DATA_S capture and SHALL be stable from the end of the payload until the next frame starts.
REQ-022 Back-to-back frames: ACTIVE=1 in the cycle after the result pulse SHALL be accepted as IDLE behaviour, with no dead cycle required.
REQ-023 Short payload: Valid=1 while count != DATA_WD SHALL produce FRAME_ERR pulse 1 cycle and go to IDLE.
REQ-024 Long payload: ACTIVE=1 while count == DATA_WD SHALL produce FRAME_ERR pulse 1 cycle and go to IDLE.
REQ-025 A gap of ACTIVE=0 and Valid=0 in DATA_S or CRC_S SHALL produce FRAME_ERR and go to IDLE.
REQ-026 Simultaneous ACTIVE=1 and Valid=1 in any state SHALL produce FRAME_ERR and go to IDLE; in IDLE no frame SHALL start.
REQ-027 Valid=1 in IDLE SHALL be ignored, with no pulse.
REQ-028 CRC_OK, CRC_ERR and FRAME_ERR SHALL be mutually exclusive and driven from registers.

Reset
REQ-029 RST=0 SHALL asynchronously force state IDLE, R=Seed, counts 0, mismatch flag 0, DATA_OUT=0, CRC_OK=0, CRC_ERR=0, FRAME_ERR=0, Busy=0.
REQ-030 Reset mid-frame SHALL discard the frame with no pulse; operation SHALL resume on the first edge after RST=1.

Structure
REQ-031 A shared package SHALL hold the CRC_WD=8 constant, the default Seed/TAPS values and the FSM state encoding; the generator SHALL use the same package.
REQ-032 The LFSR update SHALL be a sub-module crc_lfsr_step (combinational next-state from R, bit, TAPS), reusable by the generator.
REQ-033 Total RTL SHALL be approximately 120-250 lines.

Verification
REQ-034 Payload 0x00 (8 cycles ACTIVE), then Valid for 8 cycles with DATA = 0x14 LSB first -> CRC_OK pulse 1 cycle; DATA_OUT=0x00.
REQ-035 Ten payloads from DATA_h.txt, each followed by its CRC from Expec_Out_h.txt, back-to-back -> 10 CRC_OK pulses with matching DATA_OUT; a generator-to-checker loopback SHALL give the same result.
REQ-036 Payload 0x00 followed by CRC 0x1C (bit 3 flipped) -> CRC_ERR pulse; CRC_OK stays 0.
REQ-037 Seven ACTIVE cycles then Valid -> FRAME_ERR pulse; a following legal frame -> CRC_OK.
REQ-038 RST=0 asserted after 4 payload bits -> all outputs 0 immediately; the next clean frame -> CRC_OK.
REQ-039 ACTIVE and Valid both high in cycle 3 -> FRAME_ERR pulse, Busy falls the next cycle.

Source files
------------

// File: rtl/crc_checker_pkg.sv
// crc_checker_pkg: CRC width, default LFSR seed/taps and FSM state encoding shared by checker and generator.
package crc_checker_pkg;
    localparam int CRC_WD = 8;
    localparam logic [CRC_WD-1:0] SEED_DEF = 8'hD8;
    localparam logic [CRC_WD-1:0] TAPS_DEF = 8'h44;
    typedef enum logic [1:0] {IDLE, DATA_S, CRC_S} state_t;
endpackage

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step: combinational next state of the Galois LFSR for one serial bit.
module crc_lfsr_step import crc_checker_pkg::*; (
    input  logic [CRC_WD-1:0] r,
    input  logic              din,
    input  logic [CRC_WD-2:0] taps,
    output logic [CRC_WD-1:0] r_next
);
    logic fb;
    assign fb = r[0] ^ din;
    assign r_next = {fb, r[CRC_WD-1:1] ^ (taps & {(CRC_WD-1){fb}})};
endmodule

// File: rtl/crc_checker.sv
// crc_checker: serial frame receiver that captures a payload and verifies its trailing LSB-first CRC.
module crc_checker import crc_checker_pkg::*; #(
    parameter logic [CRC_WD-1:0] Seed    = SEED_DEF,
    parameter logic [CRC_WD-1:0] TAPS    = TAPS_DEF,
    parameter int                DATA_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               DATA,
    input  logic               ACTIVE,
    input  logic               Valid,
    output logic [DATA_WD-1:0] DATA_OUT,
    output logic               CRC_OK,
    output logic               CRC_ERR,
    output logic               FRAME_ERR,
    output logic               Busy
);
    localparam int CW = $clog2(DATA_WD + 1);
    localparam int KW = $clog2(CRC_WD + 1);
    state_t state;
    logic [CRC_WD-1:0] r, r_step;
    logic [CW-1:0] cnt;
    logic [KW-1:0] ccnt;
    logic mis, full, bad, pay_in, crc_in, last, err, done;
    crc_lfsr_step u_step (
        .r     (r),
        .din   (DATA),
        .taps  (TAPS[CRC_WD-2:0]),
        .r_next(r_step)
    );
    always_comb begin
        full   = cnt == CW'(DATA_WD);
        bad    = DATA != r[0];
        pay_in = ACTIVE && !Valid && (state == IDLE || (state == DATA_S && !full));
        crc_in = Valid && !ACTIVE && ((state == DATA_S && full) || state == CRC_S);
        last   = state == CRC_S && ccnt == KW'(CRC_WD - 1);
        err    = (ACTIVE && Valid) || (state != IDLE && !pay_in && !crc_in);
        done   = crc_in && last;
    end
    // Every frame end (good, bad or aborted) reloads the seed so IDLE can accept the next bit at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            r         <= Seed;
            cnt       <= '0;
            ccnt      <= '0;
            mis       <= 1'b0;
            DATA_OUT  <= '0;
            CRC_OK    <= 1'b0;
            CRC_ERR   <= 1'b0;
            FRAME_ERR <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            FRAME_ERR <= err;
            CRC_OK    <= !err && done && !(mis || bad);
            CRC_ERR   <= !err && done && (mis || bad);
            if (err || done) begin
                state <= IDLE;
                r     <= Seed;
                cnt   <= '0;
                ccnt  <= '0;
                mis   <= 1'b0;
                Busy  <= 1'b0;
            end else if (pay_in) begin
                state    <= DATA_S;
                r        <= r_step;
                DATA_OUT <= {DATA, DATA_OUT[DATA_WD-1:1]};
                cnt      <= cnt + 1'b1;
                Busy     <= 1'b1;
            end else if (crc_in) begin
                state <= CRC_S;
                r     <= r >> 1;
                mis   <= mis || bad;
                ccnt  <= ccnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: scoreboard bench for crc_checker with good, corrupted and malformed frames.
module tb_crc_checker;
    localparam int K_OK = 1, K_ERR = 2, K_FRM = 3;
    typedef struct {int kind; logic [7:0] data; bit chk;} exp_t;
    logic clk = 1'b0, rst = 1'b0, data = 1'b0, active = 1'b0, valid = 1'b0;
    logic [7:0] data_out;
    logic crc_ok, crc_err, frame_err, busy;
    int n_tests = 0, n_fail = 0;
    exp_t q[$];
    crc_checker dut (
        .CLK      (clk),
        .RST      (rst),
        .DATA     (data),
        .ACTIVE   (active),
        .Valid    (valid),
        .DATA_OUT (data_out),
        .CRC_OK   (crc_ok),
        .CRC_ERR  (crc_err),
        .FRAME_ERR(frame_err),
        .Busy     (busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] crc_of(input logic [7:0] p);
        logic [7:0] c = 8'hD8;
        for (int i = 0; i < 8; i++) begin
            logic fb = c[0] ^ p[i];
            c = c >> 1;
            if (fb) c = c ^ 8'hC4;
        end
        return c;
    endfunction
    task automatic step(input logic a, input logic v, input logic d);
        active = a;
        valid  = v;
        data   = d;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int kind, input logic [7:0] d, input bit chk);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.chk  = chk;
        q.push_back(e);
    endtask
    task automatic send_payload(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, p[i % 8]);
    endtask
    task automatic send_crc(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, c[i]);
    endtask
    task automatic frame(input logic [7:0] p, input logic [7:0] c, input int kind);
        push(kind, p, 1'b1);
        send_payload(p, 8);
        send_crc(c, 8);
    endtask
    always @(negedge clk) begin
        if (rst && (crc_ok || crc_err || frame_err)) begin
            int kind;
            kind = crc_ok ? K_OK : crc_err ? K_ERR : K_FRM;
            check("onehot", int'(crc_ok) + int'(crc_err) + int'(frame_err), 1);
            if (q.size() == 0) check("unexpected_pulse", kind, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("kind", kind, e.kind);
                if (e.chk) check("data_out", data_out, e.data);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        logic [7:0] p;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ok", crc_ok, 0);
        check("rst_err", crc_err, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        frame(8'h00, 8'h14, K_OK);
        step(1'b0, 1'b0, 1'b0);
        frame(8'hA5, crc_of(8'hA5), K_OK);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("dout_hold", data_out, 8'hA5);
        check("idle_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            p = (i == 0) ? 8'hFF : (i == 1) ? 8'h01 : (i == 2) ? 8'h80 : 8'($urandom);
            frame(p, crc_of(p), K_OK);
        end
        step(1'b0, 1'b0, 1'b0);
        frame(8'h00, 8'h1C, K_ERR);
        step(1'b0, 1'b0, 1'b0);
        push(K_FRM, 8'h00, 1'b0);
        send_payload(8'h3C, 7);
        step(1'b0, 1'b1, 1'b0);
        frame(8'h3C, crc_of(8'h3C), K_OK);
        step(1'b0, 1'b0, 1'b0);
        send_payload(8'h5A, 4);
        check("mid_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_dout", data_out, 0);
        check("arst_pulses", {crc_ok, crc_err, frame_err}, 0);
        active = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        frame(8'h5A, crc_of(8'h5A), K_OK);
        push(K_FRM, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("busy_before_both", busy, 1);
        step(1'b1, 1'b1, 1'b1);
        check("busy_after_both", busy, 0);
        push(K_FRM, 8'h00, 1'b0);
        send_payload(8'hC3, 9);
        step(1'b0, 1'b0, 1'b0);
        push(K_FRM, 8'h00, 1'b0);
        send_payload(8'h69, 8);
        send_crc(crc_of(8'h69), 3);
        step(1'b0, 1'b0, 1'b0);
        push(K_FRM, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("both_idle_busy", busy, 0);
        frame(8'h96, crc_of(8'h96), K_OK);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
